chamber_phi_mining_dispatcher: RTL and testbench

- Initiator side of the chamber hash-core start/done protocol.
- Accepts a mining job (header, target, nonce start/stride, iteration limit) and builds 512-bit message blocks with each candidate nonce.
- Drives a level-held start to a phi-SHA256 core and compares each returned hash against the target.
- Reports the first winning nonce, exhaustion, or a core timeout. Sits between the kingdom job scheduler and the chamber hash core.

---
 rtl/chamber_pkg.sv | 25 ++
 rtl/chamber_hash_compare.sv | 12 +
 rtl/chamber_phi_mining_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_chamber_phi_mining_dispatcher.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chamber_pkg.sv
// Shared types and constants for the chamber hash-core dispatcher.
package chamber_pkg;

  localparam logic [31:0] PHI_FRAC32 = 32'h9E3779B9;
  localparam int HASH_W   = 256;
  localparam int BLOCK_W  = 512;
  localparam int HEADER_W = 480;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CHECK,
    S_GAP,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic              found;
    logic              error;
    logic [31:0]       nonce;
    logic [HASH_W-1:0] hash;
  } result_t;

endpackage

// File: rtl/chamber_hash_compare.sv
// Unsigned 256-bit hash-below-target compare, combinational.
module chamber_hash_compare
  import chamber_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              below
);

  assign below = (hash < target);

endmodule

// File: rtl/chamber_phi_mining_dispatcher.sv
// Job dispatcher driving a level-start phi-SHA256 core and scanning nonces against a target.
// Build option: CHAMBER_PHI_GOLDEN_STRIDE_EN adds PHI_FRAC32 to every nonce step.
//
// state    | meaning
// S_IDLE   | job_ready high, waiting for a job
// S_LOAD   | register message block for the current nonce
// S_RUN    | core_start held, waiting for core_done or timeout
// S_CHECK  | compare hash against target, pick next nonce
// S_GAP    | one low cycle on core_start so the core clears
// S_REPORT | result offered until res_ready
module chamber_phi_mining_dispatcher
  import chamber_pkg::*;
#(
  parameter int NONCE_W      = 32,
  parameter int ITER_W       = 16,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [HEADER_W-1:0] job_header,
  input  logic [HASH_W-1:0]   job_target,
  input  logic [NONCE_W-1:0]  job_nonce_start,
  input  logic [NONCE_W-1:0]  job_stride,
  input  logic [ITER_W-1:0]   job_max_iter,
  input  logic                abort,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic [HASH_W-1:0]   core_hash,
  input  logic                core_done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_found,
  output logic [NONCE_W-1:0]  res_nonce,
  output logic [HASH_W-1:0]   res_hash,
  output logic                res_error,
  output logic                busy
);

  localparam int TMO_W = $clog2(DONE_TIMEOUT + 1);

  state_t              state_q;
  logic [HEADER_W-1:0] header_q;
  logic [HASH_W-1:0]   target_q;
  logic [HASH_W-1:0]   hash_q;
  logic [NONCE_W-1:0]  stride_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [ITER_W-1:0]   last_iter_q;
  logic [ITER_W-1:0]   iter_q;
  logic [TMO_W-1:0]    tmo_q;
  result_t             res_q;
  logic                below;
  logic [NONCE_W-1:0]  nonce_inc;

`ifdef CHAMBER_PHI_GOLDEN_STRIDE_EN
  assign nonce_inc = stride_q + NONCE_W'(PHI_FRAC32);
`else
  assign nonce_inc = stride_q;
`endif

  chamber_hash_compare u_cmp (
    .hash   (hash_q),
    .target (target_q),
    .below  (below)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      header_q    <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      stride_q    <= '0;
      nonce_q     <= '0;
      last_iter_q <= '0;
      iter_q      <= '0;
      tmo_q       <= '0;
      res_q       <= '0;
      res_valid   <= 1'b0;
      job_ready   <= 1'b1;
      core_start  <= 1'b0;
      core_block  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (job_valid && job_ready) begin
            header_q    <= job_header;
            target_q    <= job_target;
            stride_q    <= job_stride;
            nonce_q     <= job_nonce_start;
            // a zero limit still tries one nonce
            last_iter_q <= (job_max_iter == '0) ? '0 : job_max_iter - ITER_W'(1);
            iter_q      <= '0;
            job_ready   <= 1'b0;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            job_ready <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            core_block <= {header_q, nonce_q};
            core_start <= 1'b1;
            tmo_q      <= '0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            core_start <= 1'b0;
            job_ready  <= 1'b1;
            state_q    <= S_IDLE;
          end else if (core_done) begin
            hash_q     <= core_hash;
            core_start <= 1'b0;
            state_q    <= S_CHECK;
          end else if (tmo_q == TMO_W'(DONE_TIMEOUT - 1)) begin
            core_start <= 1'b0;
            res_q      <= '{found: 1'b0, error: 1'b1, nonce: nonce_q, hash: '0};
            res_valid  <= 1'b1;
            state_q    <= S_REPORT;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_CHECK: begin
          if (abort) begin
            job_ready <= 1'b1;
            state_q   <= S_IDLE;
          end else if (below || (iter_q == last_iter_q)) begin
            res_q     <= '{found: below, error: 1'b0, nonce: nonce_q, hash: hash_q};
            res_valid <= 1'b1;
            state_q   <= S_REPORT;
          end else begin
            iter_q  <= iter_q + ITER_W'(1);
            nonce_q <= nonce_q + nonce_inc;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (abort) begin
            job_ready <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_q     <= '0;
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          core_start <= 1'b0;
          job_ready  <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign res_found = res_q.found;
  assign res_error = res_q.error;
  assign res_nonce = res_q.nonce;
  assign res_hash  = res_q.hash;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_chamber_phi_mining_dispatcher.sv
// Scoreboard bench for the dispatcher with a stub hash core of programmable latency.
module tb_chamber_phi_mining_dispatcher;

`ifdef CHAMBER_PHI_GOLDEN_STRIDE_EN
  localparam logic [31:0] GOLD = 32'h9E3779B9;
`else
  localparam logic [31:0] GOLD = 32'h0;
`endif

  localparam logic [479:0] HDR = {15{32'hC0DE_5A17}};
  localparam logic [255:0] TGT = {1'b1, 255'b0};
  localparam logic [255:0] ONES = {256{1'b1}};

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid;
  logic         job_ready;
  logic [479:0] job_header;
  logic [255:0] job_target;
  logic [31:0]  job_nonce_start;
  logic [31:0]  job_stride;
  logic [15:0]  job_max_iter;
  logic         abort;
  logic         core_start;
  logic [511:0] core_block;
  logic [255:0] core_hash;
  logic         core_done;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [31:0]  res_nonce;
  logic [255:0] res_hash;
  logic         res_error;
  logic         busy;

  chamber_phi_mining_dispatcher dut (
    .clk             (clk),
    .rst             (rst),
    .job_valid       (job_valid),
    .job_ready       (job_ready),
    .job_header      (job_header),
    .job_target      (job_target),
    .job_nonce_start (job_nonce_start),
    .job_stride      (job_stride),
    .job_max_iter    (job_max_iter),
    .abort           (abort),
    .core_start      (core_start),
    .core_block      (core_block),
    .core_hash       (core_hash),
    .core_done       (core_done),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_found       (res_found),
    .res_nonce       (res_nonce),
    .res_hash        (res_hash),
    .res_error       (res_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // stub core: done after lat high cycles, hash 1 only for hit_nonce
  int          lat = 64;
  logic        never_done = 1'b0;
  logic [31:0] hit_nonce = 32'h100;
  int          scnt = 0;

  always @(posedge clk) scnt <= core_start ? scnt + 1 : 0;
  assign core_done = core_start && !never_done && (scnt == lat - 1);
  assign core_hash = (core_block[31:0] == hit_nonce) ? 256'h1 : ONES;

  typedef struct {
    logic         found;
    logic         error;
    logic [31:0]  nonce;
    logic         chk_hash;
    logic [255:0] hash;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  logic [31:0] rise_nonce[$];
  int          pulse_len[$];
  int          gap_len[$];
  logic        prev_start = 1'b0;
  int          hi_len = 0;
  int          lo_len = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=nonce %0h required=none", res_nonce);
      end else begin
        e = sbq.pop_front();
        chk("res_found", {255'b0, res_found}, {255'b0, e.found});
        chk("res_error", {255'b0, res_error}, {255'b0, e.error});
        chk("res_nonce", {224'b0, res_nonce}, {224'b0, e.nonce});
        if (e.chk_hash) chk("res_hash", res_hash, e.hash);
      end
    end
    if (core_start) begin
      if (!prev_start) begin
        rise_nonce.push_back(core_block[31:0]);
        gap_len.push_back(lo_len);
        hi_len = 0;
      end
      hi_len++;
    end else begin
      if (prev_start) pulse_len.push_back(hi_len);
      lo_len = prev_start ? 1 : lo_len + 1;
    end
    prev_start = core_start;
  end

  task automatic clear_logs();
    rise_nonce.delete();
    pulse_len.delete();
    gap_len.delete();
  endtask

  task automatic run_job(input logic [31:0] start, input logic [31:0] stride, input logic [15:0] maxi);
    int n;
    n = 0;
    @(negedge clk);
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      total++;
      bad++;
      $display("FAIL job_ready_wait actual=0 required=1");
    end
    job_header      = HDR;
    job_target      = TGT;
    job_nonce_start = start;
    job_stride      = stride;
    job_max_iter    = maxi;
    job_valid       = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || !job_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy || !job_ready) begin
      total++;
      bad++;
      $display("FAIL job_complete_timeout actual=busy required=idle");
    end
  endtask

  initial begin
    logic [31:0] expn;
    int n;
    rst = 1'b1;
    job_valid = 1'b0;
    job_header = '0;
    job_target = '0;
    job_nonce_start = '0;
    job_stride = '0;
    job_max_iter = '0;
    abort = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_job_ready", {255'b0, job_ready}, 256'h1);
    chk("reset_busy", {255'b0, busy}, 256'h0);
    chk("reset_core_start", {255'b0, core_start}, 256'h0);
    chk("reset_res_valid", {255'b0, res_valid}, 256'h0);
    chk("reset_res_nonce", {224'b0, res_nonce}, 256'h0);
    chk("reset_core_block", core_block[255:0], 256'h0);

    // first-nonce hit, 64-cycle core
    clear_logs();
    lat = 64;
    hit_nonce = 32'h100;
    sbq.push_back('{1'b1, 1'b0, 32'h100, 1'b1, 256'h1});
    run_job(32'h100, 32'h8, 16'd16);
    wait_done(500);
    chk("hit_pulses", 256'(rise_nonce.size()), 256'd1);
    if (pulse_len.size() > 0) chk("hit_start_len", 256'(pulse_len[0]), 256'd64);
    chk("hit_block_header", {32'b0, core_block[511:32]}, {32'b0, HDR});
    chk("hit_block_nonce", {224'b0, core_block[31:0]}, 256'h100);

    // exhaustion over four nonces
    clear_logs();
    lat = 5;
    hit_nonce = 32'hDEAD0000;
    sbq.push_back('{1'b0, 1'b0, 32'h10 + 32'd3 * (32'd8 + GOLD), 1'b1, ONES});
    run_job(32'h10, 32'h8, 16'd4);
    wait_done(500);
    chk("exh_pulses", 256'(rise_nonce.size()), 256'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rise_nonce.size()) begin
        expn = 32'h10 + 32'(k) * (32'd8 + GOLD);
        chk($sformatf("exh_nonce%0d", k), {224'b0, rise_nonce[k]}, {224'b0, expn});
      end
      if (k < pulse_len.size()) chk($sformatf("exh_len%0d", k), 256'(pulse_len[k]), 256'd5);
      if (k > 0 && k < gap_len.size()) chk($sformatf("exh_gap%0d", k), 256'(gap_len[k]), 256'd3);
    end

    // nonce wrap, hit on second try
    clear_logs();
    hit_nonce = 32'hFFFFFFFC + 32'd8 + GOLD;
    sbq.push_back('{1'b1, 1'b0, 32'hFFFFFFFC + 32'd8 + GOLD, 1'b1, 256'h1});
    run_job(32'hFFFFFFFC, 32'h8, 16'd10);
    wait_done(500);
    chk("wrap_pulses", 256'(rise_nonce.size()), 256'd2);

    // max_iter of zero tries exactly one nonce
    clear_logs();
    hit_nonce = 32'hDEAD0000;
    sbq.push_back('{1'b0, 1'b0, 32'h55, 1'b1, ONES});
    run_job(32'h55, 32'h1, 16'd0);
    wait_done(500);
    chk("zero_iter_pulses", 256'(rise_nonce.size()), 256'd1);

    // core never answers
    clear_logs();
    never_done = 1'b1;
    sbq.push_back('{1'b0, 1'b1, 32'h77, 1'b0, '0});
    run_job(32'h77, 32'h4, 16'd3);
    wait_done(800);
    chk("tmo_pulses", 256'(rise_nonce.size()), 256'd1);
    if (pulse_len.size() > 0) chk("tmo_start_len", 256'(pulse_len[0]), 256'd255);
    chk("tmo_core_start", {255'b0, core_start}, 256'h0);
    never_done = 1'b0;

    // abort coinciding with core_done on third attempt
    clear_logs();
    lat = 6;
    run_job(32'h200, 32'h1, 16'd10);
    n = 0;
    while (!(core_done && rise_nonce.size() == 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached", {255'b0, core_done}, 256'h1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_job_ready", {255'b0, job_ready}, 256'h1);
    chk("abort_busy", {255'b0, busy}, 256'h0);
    chk("abort_core_start", {255'b0, core_start}, 256'h0);
    repeat (20) @(negedge clk);
    chk("abort_pulses", 256'(rise_nonce.size()), 256'd3);
    chk("abort_res_valid", {255'b0, res_valid}, 256'h0);

    // backpressure: result held for 20 cycles
    clear_logs();
    lat = 4;
    hit_nonce = 32'h300;
    res_ready = 1'b0;
    sbq.push_back('{1'b1, 1'b0, 32'h300, 1'b1, 256'h1});
    run_job(32'h300, 32'h1, 16'd5);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 20; k++) begin
      chk("bp_res_valid", {255'b0, res_valid}, 256'h1);
      chk("bp_res_found", {255'b0, res_found}, 256'h1);
      chk("bp_res_nonce", {224'b0, res_nonce}, 256'h300);
      chk("bp_res_hash", res_hash, 256'h1);
      @(negedge clk);
    end
    @(posedge clk);
    #2 res_ready = 1'b1;
    wait_done(50);

    // asynchronous reset in the middle of RUN
    clear_logs();
    lat = 64;
    run_job(32'h400, 32'h1, 16'd5);
    n = 0;
    while (!core_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_core_start", {255'b0, core_start}, 256'h0);
    chk("rst_busy", {255'b0, busy}, 256'h0);
    chk("rst_job_ready", {255'b0, job_ready}, 256'h1);
    chk("rst_res_valid", {255'b0, res_valid}, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_job_ready", {255'b0, job_ready}, 256'h1);
    chk("post_rst_busy", {255'b0, busy}, 256'h0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 256'(sbq.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
